// File: rtl/memif_apb_master.sv
// rtl/memif_apb_master.sv - APB4 master bridge for single-pulse memory requests
//
// Purpose: turns single-cycle memory requests from an on-chip initiator into
// APB4 master transfers (SETUP, then ACCESS held until pready_i), and returns a
// one-cycle acknowledge carrying read data and error status. A one-entry
// pending slot lets the next request be posted while a transfer is in flight.
//
// Optional feature: define MEMIF_APB_MASTER_TIMEOUT_EN to end an ACCESS phase
// with an error after TIMEOUT_CYCLES cycles without pready_i.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   mreq_i              request pulse, taken only while mready_o=1
//   maddr_i, mwe_i      request address, 1=write / 0=read
//   mwdata_i, mstrb_i   write data and byte strobes
//   mready_o            pending slot free (combinational)
//   mack_o              one-cycle completion pulse
//   mrdata_o, mresp_o   read data / error flag, valid with mack_o, held after
//   psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o   APB master outputs
//   pready_i, pslverr_i, prdata_i                              APB slave response

module memif_apb_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mreq_i,
  input  logic [ADDR_WIDTH-1:0]   maddr_i,
  input  logic                    mwe_i,
  input  logic [DATA_WIDTH-1:0]   mwdata_i,
  input  logic [DATA_WIDTH/8-1:0] mstrb_i,
  output logic                    mready_o,
  output logic                    mack_o,
  output logic [DATA_WIDTH-1:0]   mrdata_o,
  output logic                    mresp_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  state_e state_q, state_d;

  logic                  pend_valid_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic                  pend_we_q;
  logic [DATA_WIDTH-1:0] pend_wdata_q;
  logic [STRB_WIDTH-1:0] pend_strb_q;

  logic                  accept;
  logic                  timeout;
  logic                  xfer_done;
  logic                  load_active;
  logic                  psel_d;
  logic                  penable_d;

  logic [ADDR_WIDTH-1:0] src_addr;
  logic                  src_we;
  logic [DATA_WIDTH-1:0] src_wdata;
  logic [STRB_WIDTH-1:0] src_strb;

  assign mready_o = ~pend_valid_q;
  assign accept   = mreq_i & ~pend_valid_q;

`ifdef MEMIF_APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  // Counts ACCESS cycles already spent waiting; the cycle that sees the count
  // reach TIMEOUT_CYCLES-1 without pready_i is the last one allowed.
  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == ST_SETUP) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_ACCESS && !pready_i) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  assign timeout = (state_q == ST_ACCESS) && !pready_i &&
                   (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  assign xfer_done = (state_q == ST_ACCESS) && (pready_i || timeout);

  // An idle bridge with an empty slot launches a new request straight into
  // SETUP; a request posted while busy waits in the pending slot and is
  // promoted either from IDLE or directly at the end of the current ACCESS.
  assign load_active = ((state_q == ST_IDLE) && (pend_valid_q || mreq_i)) ||
                       (xfer_done && pend_valid_q);

  always_comb begin
    src_addr  = maddr_i;
    src_we    = mwe_i;
    src_wdata = mwdata_i;
    src_strb  = mstrb_i;
    if (pend_valid_q) begin
      src_addr  = pend_addr_q;
      src_we    = pend_we_q;
      src_wdata = pend_wdata_q;
      src_strb  = pend_strb_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q || mreq_i) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (xfer_done) begin
          state_d = pend_valid_q ? ST_SETUP : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, computed from the next state so the APB controls are registered
  always_comb begin
    psel_d    = 1'b0;
    penable_d = 1'b0;
    case (state_d)
      ST_SETUP:  psel_d = 1'b1;
      ST_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
    end else if (load_active && pend_valid_q) begin
      pend_valid_q <= 1'b0;
    end else if (accept && state_q != ST_IDLE) begin
      pend_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && state_q != ST_IDLE) begin
      pend_addr_q  <= maddr_i;
      pend_we_q    <= mwe_i;
      pend_wdata_q <= mwdata_i;
      pend_strb_q  <= mstrb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pstrb_o   <= '0;
      mack_o    <= 1'b0;
      mresp_o   <= 1'b0;
      mrdata_o  <= '0;
    end else begin
      psel_o    <= psel_d;
      penable_o <= penable_d;
      mack_o    <= xfer_done;
      if (load_active) begin
        paddr_o  <= src_addr;
        pwrite_o <= src_we;
        // Reads present zero data and strobes on the bus.
        pwdata_o <= src_we ? src_wdata : '0;
        pstrb_o  <= src_we ? src_strb : '0;
      end
      if (xfer_done) begin
        // A timed-out transfer reports an error with zero data.
        mresp_o  <= pready_i ? pslverr_i : 1'b1;
        mrdata_o <= (pready_i && !pwrite_o) ? prdata_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_memif_apb_master.sv
// tb/tb_memif_apb_master.sv - self-checking bench for memif_apb_master
module tb_memif_apb_master;

  logic        clk_i;
  logic        rst_i;
  logic        mreq_i;
  logic [31:0] maddr_i;
  logic        mwe_i;
  logic [31:0] mwdata_i;
  logic [3:0]  mstrb_i;
  logic        mready_o;
  logic        mack_o;
  logic [31:0] mrdata_o;
  logic        mresp_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic        pslverr_i;
  logic [31:0] prdata_i;

  memif_apb_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .mreq_i   (mreq_i),
    .maddr_i  (maddr_i),
    .mwe_i    (mwe_i),
    .mwdata_i (mwdata_i),
    .mstrb_i  (mstrb_i),
    .mready_o (mready_o),
    .mack_o   (mack_o),
    .mrdata_o (mrdata_o),
    .mresp_o  (mresp_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .pwrite_o (pwrite_o),
    .paddr_o  (paddr_o),
    .pwdata_o (pwdata_o),
    .pstrb_o  (pstrb_o),
    .pready_i (pready_i),
    .pslverr_i(pslverr_i),
    .prdata_i (prdata_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  req_t req_q[$];
  req_t apb_q[$];
  rsp_t rsp_q[$];

  int checks   = 0;
  int failures = 0;
  int issued   = 0;
  int acks     = 0;
  bit auto_chk = 0;

  bit          rand_mode   = 0;
  int          slave_wait  = 0;
  logic        slave_err   = 0;
  logic [31:0] slave_rdata = 0;

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ack_check();
    req_t r;
    rsp_t s;
    if (req_q.size() == 0 || rsp_q.size() == 0) begin
      chk("ack_unexpected", mack_o, 0);
    end else begin
      r = req_q.pop_front();
      s = rsp_q.pop_front();
      chk("ack_rdata", mrdata_o, r.we ? 32'h0 : s.rdata);
      chk("ack_resp", mresp_o, s.err);
      acks++;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (auto_chk && mack_o) ack_check();
  endtask

  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input logic [3:0] st);
    req_t r;
    mreq_i   = 1;
    maddr_i  = a;
    mwe_i    = we;
    mwdata_i = wd;
    mstrb_i  = st;
    r.addr   = a;
    r.we     = we;
    r.wdata  = we ? wd : 32'h0;
    r.strb   = we ? st : 4'h0;
    req_q.push_back(r);
    apb_q.push_back(r);
    issued++;
    tick();
    mreq_i   = 0;
    maddr_i  = $urandom;
    mwe_i    = $urandom_range(0, 1);
    mwdata_i = $urandom;
    mstrb_i  = 4'($urandom);
  endtask

  task automatic wait_ack(input int max_cycles);
    int n;
    n = 0;
    tick();
    while (!mack_o && n < max_cycles) begin
      tick();
      n++;
    end
    chk("ack_within_bound", mack_o, 1);
  endtask

  // APB slave: random or directed wait states, checks the transfer it sees
  // against the request stream and queues the response it gave.
  initial begin
    int          wcnt;
    int          cur_wait;
    logic        cur_err;
    logic [31:0] cur_rdata;
    bit          in_access;
    req_t        snap;
    req_t        e;
    pready_i  = 0;
    pslverr_i = 0;
    prdata_i  = 0;
    in_access = 0;
    wcnt      = 0;
    cur_wait  = 0;
    cur_err   = 0;
    cur_rdata = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (psel_o && !penable_o) begin
        snap.addr  = paddr_o;
        snap.we    = pwrite_o;
        snap.wdata = pwdata_o;
        snap.strb  = pstrb_o;
      end
      if (psel_o && penable_o) begin
        if (!in_access) begin
          in_access = 1;
          wcnt      = 0;
          if (rand_mode) begin
            cur_wait  = $urandom_range(0, 3);
            cur_err   = ($urandom_range(0, 3) == 0);
            cur_rdata = $urandom;
          end else begin
            cur_wait  = slave_wait;
            cur_err   = slave_err;
            cur_rdata = slave_rdata;
          end
        end
        if (wcnt == cur_wait) begin
          pready_i  = 1;
          pslverr_i = cur_err;
          prdata_i  = cur_rdata;
          in_access = 0;
          chk("apb_addr_stable", paddr_o, snap.addr);
          chk("apb_wdata_stable", pwdata_o, snap.wdata);
          chk("apb_strb_stable", pstrb_o, snap.strb);
          if (apb_q.size() == 0) begin
            chk("apb_unexpected", psel_o, 0);
          end else begin
            e = apb_q.pop_front();
            chk("apb_addr", paddr_o, e.addr);
            chk("apb_write", pwrite_o, e.we);
            chk("apb_wdata", pwdata_o, e.wdata);
            chk("apb_strb", pstrb_o, e.strb);
            rsp_q.push_back('{rdata: cur_rdata, err: cur_err});
          end
        end else begin
          pready_i  = 0;
          pslverr_i = $urandom_range(0, 1);
          prdata_i  = $urandom;
          wcnt++;
        end
      end else begin
        pready_i  = 0;
        pslverr_i = 0;
        prdata_i  = $urandom;
        in_access = 0;
      end
    end
  end

  initial begin
    int seen_ack;
    int ack_cyc;
    int n;

    rst_i    = 1;
    mreq_i   = 0;
    maddr_i  = 0;
    mwe_i    = 0;
    mwdata_i = 0;
    mstrb_i  = 0;
    tick();
    tick();
    // reset state
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_pwrite", pwrite_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_pwdata", pwdata_o, 0);
    chk("rst_pstrb", pstrb_o, 0);
    chk("rst_mack", mack_o, 0);
    chk("rst_mresp", mresp_o, 0);
    chk("rst_mrdata", mrdata_o, 0);
    chk("rst_mready", mready_o, 1);
    rst_i    = 0;
    auto_chk = 1;
    tick();

    // zero-wait write
    slave_wait = 0;
    slave_err  = 0;
    issue(32'h0000_0010, 1, 32'hDEAD_BEEF, 4'hF);
    chk("wr_c1_psel", psel_o, 1);
    chk("wr_c1_penable", penable_o, 0);
    chk("wr_c1_paddr", paddr_o, 32'h10);
    chk("wr_c1_pwrite", pwrite_o, 1);
    chk("wr_c1_pwdata", pwdata_o, 32'hDEAD_BEEF);
    chk("wr_c1_pstrb", pstrb_o, 4'hF);
    tick();
    chk("wr_c2_penable", penable_o, 1);
    chk("wr_c2_mack", mack_o, 0);
    tick();
    chk("wr_c3_mack", mack_o, 1);
    chk("wr_c3_mresp", mresp_o, 0);
    chk("wr_c3_psel", psel_o, 0);
    tick();
    chk("wr_c4_mack", mack_o, 0);

    // read with three wait states
    slave_wait  = 3;
    slave_rdata = 32'h1234_5678;
    issue(32'h0000_0020, 0, 32'hFFFF_FFFF, 4'hF);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      chk("rd_mack_timing", mack_o, (c == 6));
      if (c <= 5) begin
        chk("rd_pstrb_zero", pstrb_o, 0);
        chk("rd_pwdata_zero", pwdata_o, 0);
        chk("rd_penable", penable_o, (c >= 2));
      end
    end
    chk("rd_mrdata", mrdata_o, 32'h1234_5678);
    tick();
    tick();
    chk("rd_mrdata_held", mrdata_o, 32'h1234_5678);

    // back-to-back posting
    slave_wait  = 0;
    slave_rdata = 32'h0BAD_F00D;
    issue(32'h0000_0100, 1, 32'h1111_2222, 4'h3);
    chk("b2b_c1_mready", mready_o, 1);
    issue(32'h0000_0104, 0, 32'h0, 4'h0);
    chk("b2b_c2_mready", mready_o, 0);
    chk("b2b_c2_penable", penable_o, 1);
    tick();
    chk("b2b_c3_mack", mack_o, 1);
    chk("b2b_c3_psel", psel_o, 1);
    chk("b2b_c3_penable", penable_o, 0);
    chk("b2b_c3_paddr", paddr_o, 32'h104);
    chk("b2b_c3_mready", mready_o, 1);
    tick();
    chk("b2b_c4_mack", mack_o, 0);
    tick();
    chk("b2b_c5_mack", mack_o, 1);
    chk("b2b_c5_mrdata", mrdata_o, 32'h0BAD_F00D);
    tick();

    // slave error then clean transfer
    slave_err = 1;
    issue(32'h0000_0040, 1, 32'hA5A5_A5A5, 4'h5);
    wait_ack(10);
    chk("err_mresp", mresp_o, 1);
    slave_err   = 0;
    slave_rdata = 32'h5A5A_0001;
    issue(32'h0000_0044, 0, 32'h0, 4'h0);
    wait_ack(10);
    chk("clean_mresp", mresp_o, 0);
    tick();

    // reset during ACCESS with a request pending
    slave_wait = 50;
    issue(32'h0000_0200, 1, 32'hCAFE_0000, 4'hF);
    tick();
    issue(32'h0000_0204, 0, 32'h0, 4'h0);
    chk("rst_mid_penable", penable_o, 1);
    chk("rst_mid_mready", mready_o, 0);
    rst_i = 1;
    tick();
    rst_i = 0;
    req_q.delete();
    apb_q.delete();
    rsp_q.delete();
    chk("rstmid_psel", psel_o, 0);
    chk("rstmid_penable", penable_o, 0);
    chk("rstmid_pwrite", pwrite_o, 0);
    chk("rstmid_paddr", paddr_o, 0);
    chk("rstmid_pwdata", pwdata_o, 0);
    chk("rstmid_pstrb", pstrb_o, 0);
    chk("rstmid_mready", mready_o, 1);
    chk("rstmid_mack", mack_o, 0);
    seen_ack = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mack_o) seen_ack++;
    end
    chk("rstmid_no_ack", seen_ack, 0);
    chk("rstmid_idle_psel", psel_o, 0);

`ifdef MEMIF_APB_MASTER_TIMEOUT_EN
    slave_wait  = 0;
    slave_rdata = 32'hCAFE_F00D;
    issue(32'h0000_0300, 0, 32'h0, 4'h0);
    wait_ack(10);
    chk("to_pre_mrdata", mrdata_o, 32'hCAFE_F00D);
    tick();
    slave_wait = 1000;
    auto_chk   = 0;
    issue(32'h0000_0304, 0, 32'h0, 4'h0);
    chk("to_c1_psel", psel_o, 1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("to_access_penable", penable_o, 1);
      chk("to_access_mack", mack_o, 0);
    end
    tick();
    chk("to_c6_mack", mack_o, 1);
    chk("to_c6_mresp", mresp_o, 1);
    chk("to_c6_mrdata", mrdata_o, 0);
    chk("to_c6_psel", psel_o, 0);
    chk("to_c6_penable", penable_o, 0);
    tick();
    chk("to_c7_mack", mack_o, 0);
    req_q.delete();
    apb_q.delete();
    rsp_q.delete();
    issued--;
    auto_chk = 1;
`else
    slave_wait  = 20;
    slave_rdata = 32'h7777_1234;
    issue(32'h0000_0300, 0, 32'h0, 4'h0);
    ack_cyc = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) tick();
      if (mack_o && ack_cyc == 0) ack_cyc = c;
    end
    chk("long_wait_ack_cycle", ack_cyc, 23);
    chk("long_wait_mrdata", mrdata_o, 32'h7777_1234);
`endif

    // randomized traffic against the transaction-level model
    issued    = 0;
    acks      = 0;
    rand_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if (mready_o && $urandom_range(0, 2) != 0) begin
        issue($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      end else begin
        tick();
      end
    end
    n = 0;
    while (req_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("rand_drained", req_q.size(), 0);
    chk("rand_ack_count", acks, issued);
    tick();
    tick();
    chk("rand_end_psel", psel_o, 0);
    chk("rand_end_mready", mready_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
